// File: rtl/axi_ram_bist.sv
// AXI4 RAM self-test: fills a region with an address^Seed pattern using 4 KB-safe INCR bursts, then reads it back and checks each beat.
// Optional AXI_RAM_BIST_ERR_STOP_EN: stop issuing read bursts after the first error.
module axi_ram_bist #(
    parameter int          AddressWidth = 20,
    parameter int          DataWidth    = 32,
    parameter int          MaxBurstLen  = 16,
    parameter logic [31:0] Seed         = 32'hA5A5_5A5A
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [AddressWidth-1:0] base_addr,
    input  logic [15:0]             num_beats,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [AddressWidth-1:0] m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DataWidth-1:0]    m_axi_wdata,
    output logic                    m_axi_wlast,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [AddressWidth-1:0] m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [DataWidth-1:0]    m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    localparam int BeatBytes = DataWidth / 8;
    localparam int BeatShift = $clog2(BeatBytes);
    localparam int Lanes     = DataWidth / 32;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        FIN
    } state_t;

    state_t state, state_nxt;

    logic [AddressWidth-1:0] base_q;
    logic [AddressWidth-1:0] burst_addr_q;
    logic [AddressWidth-1:0] beat_addr_q;
    logic [15:0]             num_q;
    logic [15:0]             rem_q;
    logic [7:0]              len_q;
    logic [7:0]              beat_cnt_q;
    logic                    err_q;

    // Beats for the next burst: limited by what is left, the max burst and the 4 KB page end.
    function automatic logic [8:0] burst_beats(input logic [11:0] page_off, input logic [15:0] left);
        logic [12:0] to_page;
        logic [16:0] n;
        to_page = (13'h1000 - {1'b0, page_off}) >> BeatShift;
        n = {1'b0, left};
        if (n > 17'(MaxBurstLen)) n = 17'(MaxBurstLen);
        if (n > {4'd0, to_page})  n = {4'd0, to_page};
        return 9'(n);
    endfunction

    function automatic logic [DataWidth-1:0] pattern(input logic [AddressWidth-1:0] a);
        logic [31:0] lane;
        lane = 32'(a) ^ Seed;
        return {Lanes{lane}};
    endfunction

    logic [AddressWidth-1:0] start_addr;
    logic [AddressWidth-1:0] burst_bytes;
    logic [8:0]              start_beats;
    logic [8:0]              cont_beats;
    logic [8:0]              rd_beats;
    logic [DataWidth-1:0]    expect_dat;
    logic                    beat_last;
    logic                    addr_fire;
    logic                    w_fire;
    logic                    b_fire;
    logic                    r_fire;
    logic                    beat_err;
    logic                    stop_rd;

    assign start_addr  = base_addr & ~AddressWidth'(BeatBytes - 1);
    assign burst_bytes = (AddressWidth'(len_q) + AddressWidth'(1)) << BeatShift;
    assign start_beats = burst_beats(start_addr[11:0], num_beats);
    assign cont_beats  = burst_beats(burst_addr_q[11:0], rem_q);
    assign rd_beats    = burst_beats(base_q[11:0], num_q);
    assign expect_dat  = pattern(beat_addr_q);
    assign beat_last   = (beat_cnt_q == len_q);

    assign addr_fire = ((state == WR_ADDR) && m_axi_awready) || ((state == RD_ADDR) && m_axi_arready);
    assign w_fire    = (state == WR_DATA) && m_axi_wready;
    assign b_fire    = (state == WR_RESP) && m_axi_bvalid;
    assign r_fire    = (state == RD_DATA) && m_axi_rvalid;
    // Progress follows the beat count; a wrong rlast is only flagged.
    assign beat_err  = r_fire && ((m_axi_rresp != 2'b00) || (m_axi_rdata != expect_dat) ||
                                  (m_axi_rlast != beat_last));

`ifdef AXI_RAM_BIST_ERR_STOP_EN
    assign stop_rd = err_q | beat_err;
`else
    assign stop_rd = 1'b0;
`endif

    assign err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        busy          = 1'b0;
        done          = 1'b0;
        m_axi_awaddr  = '0;
        m_axi_awlen   = '0;
        m_axi_awvalid = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wlast   = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_araddr  = '0;
        m_axi_arlen   = '0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (num_beats == 16'd0) ? FIN : WR_ADDR;
            end
            WR_ADDR: begin
                busy          = 1'b1;
                m_axi_awaddr  = burst_addr_q;
                m_axi_awlen   = len_q;
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_nxt = WR_DATA;
            end
            WR_DATA: begin
                busy         = 1'b1;
                m_axi_wdata  = expect_dat;
                m_axi_wlast  = beat_last;
                m_axi_wvalid = 1'b1;
                if (m_axi_wready && beat_last) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                busy         = 1'b1;
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_nxt = (rem_q != 16'd0) ? WR_ADDR : RD_ADDR;
            end
            RD_ADDR: begin
                busy          = 1'b1;
                m_axi_araddr  = burst_addr_q;
                m_axi_arlen   = len_q;
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                busy         = 1'b1;
                m_axi_rready = 1'b1;
                if (m_axi_rvalid && beat_last)
                    state_nxt = ((rem_q != 16'd0) && !stop_rd) ? RD_ADDR : FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q       <= '0;
            burst_addr_q <= '0;
            beat_addr_q  <= '0;
            num_q        <= '0;
            rem_q        <= '0;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q       <= start_addr;
                        num_q        <= num_beats;
                        burst_addr_q <= start_addr;
                        rem_q        <= num_beats;
                        len_q        <= 8'(start_beats - 9'd1);
                        err_q        <= 1'b0;
                    end
                end
                WR_ADDR, RD_ADDR: begin
                    if (addr_fire) begin
                        beat_addr_q  <= burst_addr_q;
                        beat_cnt_q   <= '0;
                        rem_q        <= rem_q - 16'(len_q) - 16'd1;
                        burst_addr_q <= burst_addr_q + burst_bytes;
                    end
                end
                WR_DATA: begin
                    if (w_fire) begin
                        beat_addr_q <= beat_addr_q + AddressWidth'(BeatBytes);
                        beat_cnt_q  <= beat_cnt_q + 8'd1;
                    end
                end
                WR_RESP: begin
                    if (b_fire) begin
                        if (m_axi_bresp != 2'b00) err_q <= 1'b1;
                        if (rem_q != 16'd0) begin
                            len_q <= 8'(cont_beats - 9'd1);
                        end else begin
                            burst_addr_q <= base_q;
                            rem_q        <= num_q;
                            len_q        <= 8'(rd_beats - 9'd1);
                        end
                    end
                end
                RD_DATA: begin
                    if (r_fire) begin
                        beat_addr_q <= beat_addr_q + AddressWidth'(BeatBytes);
                        beat_cnt_q  <= beat_cnt_q + 8'd1;
                        if (beat_err) err_q <= 1'b1;
                        if (beat_last && (rem_q != 16'd0)) len_q <= 8'(cont_beats - 9'd1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_bist.sv
// Directed bench for axi_ram_bist with a behavioural AXI RAM responder driven on the falling edge.
module tb_axi_ram_bist;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [19:0] base_addr;
    logic [15:0] num_beats;
    logic        busy, done, err;
    logic [19:0] m_axi_awaddr, m_axi_araddr;
    logic [7:0]  m_axi_awlen, m_axi_arlen;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata, m_axi_rdata;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready;
    logic        m_axi_arvalid, m_axi_arready;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

    always #5 clk = ~clk;

    axi_ram_bist dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_beats(num_beats),
        .busy(busy), .done(done), .err(err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    int tests = 0;
    int fails = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Responder state
    logic [31:0] mem [0:8191];
    bit          stall = 1'b0;
    int          inj_beat = -1;
    logic [1:0]  bresp_inj = 2'b00;
    logic [19:0] wr_ptr, rd_ptr;
    int          rd_left, rd_beat, w_cnt, done_cnt, busy_cnt, viol;
    bit          b_pend;
    bit          f_aw, f_w, f_b, f_ar, f_r;
    logic [19:0] c_awaddr, c_araddr;
    logic [7:0]  c_awlen, c_arlen;
    logic [31:0] c_wdata;
    logic        c_wlast;
    bit          p_awv, p_wv, p_arv;
    logic [27:0] p_aw, p_ar;
    logic [32:0] p_w;
    logic [19:0] aw_addr_q[$], ar_addr_q[$];
    logic [7:0]  aw_len_q[$], ar_len_q[$];

    task automatic slave_step();
        if (rst) begin
            {f_aw, f_w, f_b, f_ar, f_r} = '0;
            {p_awv, p_wv, p_arv} = '0;
            b_pend = 1'b0; rd_left = 0;
            m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
            m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
            m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rlast = 1'b0;
            return;
        end
        // payloads must hold while valid waits for ready
        if (p_awv && !f_aw && (!m_axi_awvalid || {m_axi_awaddr, m_axi_awlen} != p_aw)) viol++;
        if (p_wv && !f_w && (!m_axi_wvalid || {m_axi_wdata, m_axi_wlast} != p_w)) viol++;
        if (p_arv && !f_ar && (!m_axi_arvalid || {m_axi_araddr, m_axi_arlen} != p_ar)) viol++;
        if (f_aw) begin
            wr_ptr = c_awaddr; aw_addr_q.push_back(c_awaddr); aw_len_q.push_back(c_awlen);
        end
        if (f_w) begin
            mem[wr_ptr[14:2]] = c_wdata; wr_ptr += 20'd4; w_cnt++;
            if (c_wlast) b_pend = 1'b1;
        end
        if (f_b) b_pend = 1'b0;
        if (f_ar) begin
            rd_ptr = c_araddr; rd_left = int'(c_arlen) + 1;
            ar_addr_q.push_back(c_araddr); ar_len_q.push_back(c_arlen);
        end
        if (f_r) begin
            rd_ptr += 20'd4; rd_left--; rd_beat++;
        end
        m_axi_awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        m_axi_arready = 1'b1;
        m_axi_bvalid  = b_pend;
        m_axi_bresp   = bresp_inj;
        m_axi_rvalid  = (rd_left > 0) && (stall ? 1'($urandom_range(0, 1)) : 1'b1);
        m_axi_rdata   = mem[rd_ptr[14:2]] ^ ((rd_beat == inj_beat) ? 32'd1 : 32'd0);
        m_axi_rlast   = (rd_left == 1);
        m_axi_rresp   = 2'b00;
        f_aw = m_axi_awvalid && m_axi_awready; c_awaddr = m_axi_awaddr; c_awlen = m_axi_awlen;
        f_w  = m_axi_wvalid && m_axi_wready;   c_wdata = m_axi_wdata;   c_wlast = m_axi_wlast;
        f_b  = m_axi_bvalid && m_axi_bready;
        f_ar = m_axi_arvalid && m_axi_arready; c_araddr = m_axi_araddr; c_arlen = m_axi_arlen;
        f_r  = m_axi_rvalid && m_axi_rready;
        p_awv = m_axi_awvalid; p_aw = {m_axi_awaddr, m_axi_awlen};
        p_wv  = m_axi_wvalid;  p_w  = {m_axi_wdata, m_axi_wlast};
        p_arv = m_axi_arvalid; p_ar = {m_axi_araddr, m_axi_arlen};
        done_cnt += int'(done);
        busy_cnt += int'(busy);
    endtask

    initial forever begin
        @(negedge clk);
        slave_step();
    end

    logic first_awv, first_busy;

    task automatic kick(input logic [19:0] b, input logic [15:0] n);
        aw_addr_q.delete(); aw_len_q.delete(); ar_addr_q.delete(); ar_len_q.delete();
        rd_beat = 0; done_cnt = 0; busy_cnt = 0; viol = 0; w_cnt = 0;
        @(negedge clk);
        base_addr = b; num_beats = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        first_awv = m_axi_awvalid; first_busy = busy;
    endtask

    task automatic run_region(input string tag, input logic [19:0] b, input logic [15:0] n);
        bit seen = 1'b0;
        kick(b, n);
        for (int i = 0; i < 3000; i++) begin
            if (done) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check_eq({tag, "_done_seen"}, 64'(seen), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        bit seen;
        rst = 1'b1; start = 1'b0; base_addr = '0; num_beats = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_outputs",
                 {busy, done, err, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                  m_axi_arvalid, m_axi_rready, m_axi_awlen, m_axi_arlen}, '0);
        check_eq("reset_addr_data", {m_axi_awaddr, m_axi_araddr, m_axi_wdata}, '0);
        rst = 1'b0;

        // 40 beats from 0: 16 + 16 + 8
        run_region("t1", 20'h00000, 16'd40);
        check_eq("t1_first_awvalid", 64'(first_awv), 64'd1);
        check_eq("t1_first_busy", 64'(first_busy), 64'd1);
        check_eq("t1_aw_cnt", 64'(aw_len_q.size()), 64'd3);
        check_eq("t1_aw_lens", {aw_len_q[0], aw_len_q[1], aw_len_q[2]}, {8'd15, 8'd15, 8'd7});
        check_eq("t1_aw_addr2", 64'(aw_addr_q[2]), 64'h80);
        check_eq("t1_ar_cnt", 64'(ar_len_q.size()), 64'd3);
        check_eq("t1_ar_len2", 64'(ar_len_q[2]), 64'd7);
        check_eq("t1_err", 64'(err), 64'd0);
        check_eq("t1_done_pulses", 64'(done_cnt), 64'd1);
        check_eq("t1_busy_after", 64'(busy), 64'd0);
        check_eq("t1_mem0", 64'(mem[0]), 64'hA5A5_5A5A);
        check_eq("t1_mem1", 64'(mem[1]), 64'hA5A5_5A5E);
        check_eq("t1_mem39", 64'(mem[39]), 64'hA5A5_5AC6);

        // 4 KB split
        run_region("t2", 20'h00FF0, 16'd8);
        check_eq("t2_aw_cnt", 64'(aw_len_q.size()), 64'd2);
        check_eq("t2_aw0", {aw_addr_q[0], aw_len_q[0]}, {20'h00FF0, 8'd3});
        check_eq("t2_aw1", {aw_addr_q[1], aw_len_q[1]}, {20'h01000, 8'd3});
        check_eq("t2_ar1", {ar_addr_q[1], ar_len_q[1]}, {20'h01000, 8'd3});
        check_eq("t2_err", 64'(err), 64'd0);
        check_eq("t2_mem1000", 64'(mem[1024]), 64'hA5A5_4A5A);

        // flip rdata bit 0 on read beat 5
        inj_beat = 5;
        run_region("t3", 20'h00000, 16'd40);
        inj_beat = -1;
        check_eq("t3_err", 64'(err), 64'd1);
        check_eq("t3_done_pulses", 64'(done_cnt), 64'd1);
`ifdef AXI_RAM_BIST_ERR_STOP_EN
        check_eq("t3_ar_cnt", 64'(ar_len_q.size()), 64'd1);
`else
        check_eq("t3_ar_cnt", 64'(ar_len_q.size()), 64'd3);
`endif

        // error write response
        bresp_inj = 2'b10;
        run_region("t4", 20'h00100, 16'd4);
        bresp_inj = 2'b00;
        check_eq("t4_err", 64'(err), 64'd1);
        check_eq("t4_ar_cnt", 64'(ar_len_q.size()), 64'd1);

        // random backpressure; err must clear on the new start
        stall = 1'b1;
        run_region("t5", 20'h00200, 16'd24);
        stall = 1'b0;
        check_eq("t5_err", 64'(err), 64'd0);
        check_eq("t5_stable_viol", 64'(viol), 64'd0);
        check_eq("t5_done_pulses", 64'(done_cnt), 64'd1);
        check_eq("t5_aw_cnt", 64'(aw_len_q.size()), 64'd2);
        check_eq("t5_aw_len1", 64'(aw_len_q[1]), 64'd7);
        check_eq("t5_mem_last", 64'(mem[151]), 64'hA5A5_5806);

        // reset in the middle of a write burst
        kick(20'h00000, 16'd32);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (w_cnt >= 3) begin seen = 1'b1; break; end
            @(negedge clk);
        end
        check_eq("t6_reached_wdata", 64'(seen), 64'd1);
        check_eq("t6_wvalid_before", 64'(m_axi_wvalid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_rst_outputs",
                 {busy, done, err, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                  m_axi_arvalid, m_axi_rready, m_axi_awlen, m_axi_arlen}, '0);
        check_eq("t6_rst_addr_data", {m_axi_awaddr, m_axi_araddr, m_axi_wdata}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_region("t7", 20'h00300, 16'd4);
        check_eq("t7_err", 64'(err), 64'd0);
        check_eq("t7_aw", {aw_len_q.size() == 1, aw_addr_q[0], aw_len_q[0]}, {1'b1, 20'h00300, 8'd3});
        check_eq("t7_done_pulses", 64'(done_cnt), 64'd1);

        // zero-length region
        kick(20'h00400, 16'd0);
        check_eq("t8_done_next", 64'(done), 64'd1);
        check_eq("t8_busy_next", 64'(busy), 64'd0);
        @(negedge clk);
        check_eq("t8_done_single", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        check_eq("t8_busy_never", 64'(busy_cnt), 64'd0);
        check_eq("t8_aw_none", 64'(aw_len_q.size()), 64'd0);
        check_eq("t8_err", 64'(err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
